// File: rtl/uart_tx_buf_if.sv
// Push-side bus of uart_tx_buf: byte strobe toward the buffer, FIFO status back.
interface uart_tx_buf_if;
    logic       tx_flag;
    logic [7:0] tx_data;
    logic       full;
    logic       ovf_flag;

    modport master (output tx_flag, output tx_data, input full, input ovf_flag);
    modport slave  (input tx_flag, input tx_data, output full, output ovf_flag);
endinterface

// File: rtl/uart_tx_buf.sv
// uart_tx_buf: byte FIFO draining as 8N1 UART frames on tx.
// Define UART_TX_PARITY_EN to insert an even-parity bit between d7 and stop.
module uart_tx_buf #(
    parameter int CLK_FREQ     = 50_000_000,
    parameter int BAUD         = 9600,
    parameter int BAUD_CNT_MAX = CLK_FREQ / BAUD,
    parameter int DEPTH_LOG2   = 4
) (
    input  logic         sclk,
    input  logic         rst_n,
    uart_tx_buf_if.slave bus,
    output logic         tx,
    output logic         busy
);
    localparam int DEPTH  = 2 ** DEPTH_LOG2;
    localparam int CW     = DEPTH_LOG2 + 1;
    localparam int BAUD_W = (BAUD_CNT_MAX > 1) ? $clog2(BAUD_CNT_MAX) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(BAUD_CNT_MAX - 1);
    localparam logic [CW-1:0]     COUNT_FULL = CW'(DEPTH);
`ifdef UART_TX_PARITY_EN
    localparam logic [3:0] LAST_BIT = 4'd10;
`else
    localparam logic [3:0] LAST_BIT = 4'd9;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2
    } state_t;

`ifdef UART_TX_PARITY_EN
    function automatic logic even_parity(input logic [7:0] data);
        even_parity = ^data;
    endfunction
`endif

    state_t                state_r, state_next_s;
    logic [7:0]            mem_r [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_r, rd_ptr_r;
    logic [CW-1:0]         count_r, count_next_s;
    logic [BAUD_W-1:0]     baud_cnt_r, baud_cnt_next_s;
    logic [3:0]            bit_cnt_r, bit_cnt_next_s;
    logic [7:0]            shift_r, shift_next_s;
    logic                  tx_r, tx_next_s;
    logic                  busy_r, full_r, ovf_r;
    logic                  push_s, drop_s, pop_s;
    logic                  baud_wrap_s, frame_end_s;
`ifdef UART_TX_PARITY_EN
    logic                  parity_r, parity_next_s;
`endif

    // The full test uses the pre-edge count, so a same-cycle pop never makes room.
    assign push_s      = bus.tx_flag & (count_r != COUNT_FULL);
    assign drop_s      = bus.tx_flag & (count_r == COUNT_FULL);
    assign baud_wrap_s = (baud_cnt_r == BAUD_LAST);
    assign frame_end_s = (state_r == SEND) & baud_wrap_s & (bit_cnt_r == LAST_BIT);

    // State register
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; every entry into LOAD pops one byte
    always_comb begin
        state_next_s = state_r;
        pop_s        = 1'b0;
        case (state_r)
            IDLE: begin
                if (count_r != {CW{1'b0}}) begin
                    state_next_s = LOAD;
                    pop_s        = 1'b1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            LOAD: state_next_s = SEND;
            SEND: begin
                if (frame_end_s) begin
                    if (count_r != {CW{1'b0}}) begin
                        state_next_s = LOAD;
                        pop_s        = 1'b1;
                    end else begin
                        state_next_s = IDLE;
                    end
                end else begin
                    state_next_s = SEND;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Output logic: next values of the serial line, bit timing and shift register
    always_comb begin
        tx_next_s       = tx_r;
        baud_cnt_next_s = baud_cnt_r;
        bit_cnt_next_s  = bit_cnt_r;
        shift_next_s    = shift_r;
`ifdef UART_TX_PARITY_EN
        parity_next_s   = parity_r;
`endif
        case (state_r)
            IDLE: begin
                tx_next_s    = 1'b1;
                shift_next_s = pop_s ? mem_r[rd_ptr_r] : shift_r;
            end
            LOAD: begin
                tx_next_s       = 1'b0;
                baud_cnt_next_s = {BAUD_W{1'b0}};
                bit_cnt_next_s  = 4'd0;
`ifdef UART_TX_PARITY_EN
                parity_next_s   = even_parity(shift_r);
`endif
            end
            SEND: begin
                if (baud_wrap_s) begin
                    baud_cnt_next_s = {BAUD_W{1'b0}};
                    bit_cnt_next_s  = bit_cnt_r + 4'd1;
                    if (bit_cnt_r < 4'd8) begin
                        tx_next_s    = shift_r[0];
                        shift_next_s = {1'b0, shift_r[7:1]};
                    end
`ifdef UART_TX_PARITY_EN
                    else if (bit_cnt_r == 4'd8) begin
                        tx_next_s = parity_r;
                    end
`endif
                    else begin
                        tx_next_s    = 1'b1;
                        shift_next_s = pop_s ? mem_r[rd_ptr_r] : shift_r;
                    end
                end else begin
                    baud_cnt_next_s = baud_cnt_r + BAUD_W'(1);
                end
            end
            default: tx_next_s = 1'b1;
        endcase
    end

    // FIFO occupancy: push and pop together leave the count unchanged
    always_comb begin
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CW'(1);
            2'b01:   count_next_s = count_r - CW'(1);
            default: count_next_s = count_r;
        endcase
    end

    // FIFO storage (no reset needed, validity is tracked by the count)
    always_ff @(posedge sclk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= bus.tx_data;
        end
    end

    // FIFO pointers and count
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {DEPTH_LOG2{1'b0}};
            rd_ptr_r <= {DEPTH_LOG2{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + DEPTH_LOG2'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + DEPTH_LOG2'(1);
            end
            count_r <= count_next_s;
        end
    end

    // Datapath and status registers; status reflects the post-edge state
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            tx_r       <= 1'b1;
            baud_cnt_r <= {BAUD_W{1'b0}};
            bit_cnt_r  <= 4'd0;
            shift_r    <= 8'd0;
`ifdef UART_TX_PARITY_EN
            parity_r   <= 1'b0;
`endif
            busy_r     <= 1'b0;
            full_r     <= 1'b0;
            ovf_r      <= 1'b0;
        end else begin
            tx_r       <= tx_next_s;
            baud_cnt_r <= baud_cnt_next_s;
            bit_cnt_r  <= bit_cnt_next_s;
            shift_r    <= shift_next_s;
`ifdef UART_TX_PARITY_EN
            parity_r   <= parity_next_s;
`endif
            busy_r     <= (state_next_s != IDLE) | (count_next_s != {CW{1'b0}});
            full_r     <= (count_next_s == COUNT_FULL);
            ovf_r      <= drop_s;
        end
    end

    assign tx           = tx_r;
    assign busy         = busy_r;
    assign bus.full     = full_r;
    assign bus.ovf_flag = ovf_r;
endmodule

// File: doc/uart_tx_buf.md
Name: uart_tx_buf

Overview:
Downstream stage of the Sobel line-buffer controller. It takes the controller's processed-pixel stream (tx_flag/tx_data) and returns it to the host over UART. Bytes land in a small synchronous FIFO, so pixel bursts that arrive faster than the baud rate are absorbed. The FIFO then drains as 8N1 frames on tx.

Parameters:
CLK_FREQ, 50_000_000, sclk frequency in Hz
BAUD, 9600, line rate in bit/s
BAUD_CNT_MAX, CLK_FREQ/BAUD (5208), sclk cycles per bit; integer divide, truncated
DEPTH_LOG2, 4, FIFO depth is 2**DEPTH_LOG2 (16 bytes)

Ports:
sclk  in  1  system clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
tx_flag  in  1  one-cycle strobe; tx_data valid
tx_data  in  8  byte to transmit
tx  out  1  UART serial line, idle high
busy  out  1  high while a frame is on the line or the FIFO is non-empty
full  out  1  FIFO count == 2**DEPTH_LOG2
ovf_flag  out  1  one-cycle pulse when a byte is dropped on a full FIFO

Behaviour:
- Reset (async, rst_n=0): tx=1, busy=0, full=0, ovf_flag=0; FIFO pointers, count, baud counter, bit counter and shift register cleared; FSM to IDLE. Reset mid-frame truncates the frame: tx goes to 1 immediately and buffered bytes are discarded.
- FIFO write: tx_flag=1 and count<DEPTH at an edge -> byte stored at wr_ptr, wr_ptr+1 mod DEPTH.
- Full-FIFO write: tx_flag=1 with count==DEPTH -> byte dropped, ovf_flag=1 for the next cycle only. The full check uses the pre-edge count, so a same-cycle pop does not make room.
- FIFO read: a pop happens only on the FSM entering LOAD; rd_ptr+1 mod DEPTH. Simultaneous push and pop leaves count unchanged.
- Count width is DEPTH_LOG2+1.
- FSM states:
  - IDLE: tx=1. If count!=0, pop and go to LOAD.
  - LOAD: one cycle. Shift register <= popped byte, bit_cnt=0, baud_cnt=0, tx<=0 (start bit). Go to SEND.
  - SEND: baud_cnt counts 0..BAUD_CNT_MAX-1. At wrap, bit_cnt+1 and tx advances through the sequence start, d0..d7 (LSB first), stop(1).
  - End of SEND: when the stop bit's baud_cnt wraps, go to LOAD (with a pop) if count!=0, else go to IDLE.
- Timing: each bit is held exactly BAUD_CNT_MAX cycles. The stop bit is held BAUD_CNT_MAX+1 cycles on back-to-back frames because of the LOAD cycle.
- Latency: from an idle, empty state, tx_flag sampled at edge N -> IDLE sees count=1 at N+1 and pops -> tx falls low after edge N+2.
- busy = (state!=IDLE) | (count!=0), registered.
- All outputs are registered; there is no combinational path from inputs to outputs.

Optional Feature:
Macro: UART_TX_PARITY_EN
- Defined: an even-parity bit (XOR of d0..d7) is inserted between d7 and the stop bit. A frame is 11 bits (11*BAUD_CNT_MAX cycles), and the bit-counter range extends accordingly.
- Not defined: plain 8N1, 10 bits per frame; no parity logic present.

Test Plan:
Bench uses CLK_FREQ=1000, BAUD=100, so BAUD_CNT_MAX=10.
- Single byte, idle: tx_flag with 0xA5 at edge N -> tx=0 from N+2 for 10 cycles. Then bits 1,0,1,0,0,1,0,1 for 10 cycles each, then 1. busy drops after the stop bit; 100 cycles of frame total.
- Burst: 3 consecutive-cycle strobes 0x01,0x02,0x03 -> three frames in order, each stop bit 11 cycles between frames. Decoded bytes 01,02,03; no ovf_flag.
- Overflow: 18 strobes in consecutive cycles while idle (byte k = k) -> 16 buffered, full=1. The 18th strobe raises ovf_flag for exactly one cycle and its byte is dropped. Serial output decodes bytes in order from 0x00, with one byte from the 17th/18th strobes missing.
- Reset mid-frame: assert rst_n=0 during d3 of a frame with 4 bytes queued -> tx=1 asynchronously and busy=0. After release, no further frames appear.
- Push at drain boundary: strobe in the same cycle the FSM pops the last byte (count 1 -> push+pop) -> count stays 1 and the next frame follows with no idle gap.
- With UART_TX_PARITY_EN: send 0x07 -> parity bit 1 after d7, frame 110 cycles; send 0x03 -> parity bit 0.
